// File: rtl/seven_seg_if.sv
// seven_seg_if: signal bundle for one seven-segment digit.
//
// Signals:
//   IN    [3:0] hex nibble to display (driven by the master)
//   OUT   [6:0] active-low segment drive {g,f,e,d,c,b,a} (driven by the digit)
//   I_RBI       ripple-blank in, only with SEVENSEG_RBL_EN (driven by the master)
//   O_RBO       ripple-blank out, only with SEVENSEG_RBL_EN (driven by the digit)
//
// Handshake: none. IN is a level that the digit samples on every rising clock
// edge; there is no valid/ready pair and the digit can never stall the source.
//
// Optional feature macro: SEVENSEG_RBL_EN adds the ripple-blanking pair.

interface seven_seg_if;
    logic [3:0] IN;
    logic [6:0] OUT;
`ifdef SEVENSEG_RBL_EN
    logic       I_RBI;
    logic       O_RBO;

    modport master (output IN, output I_RBI, input OUT, input O_RBO);
    modport slave  (input IN, input I_RBI, output OUT, output O_RBO);
`else
    modport master (output IN, input OUT);
    modport slave  (input IN, output OUT);
`endif
endinterface

// File: rtl/seven_seg.sv
// seven_seg: hexadecimal-to-seven-segment decoder with a registered output,
// for one DE2-style HEX display digit (active-low segments).
//
// Ports:
//   I_CLK    input   sole clock, all state updates on its rising edge
//   I_RST_N  input   asynchronous active-low reset; blanks the display
//   bus      seven_seg_if.slave
//              IN    [3:0] nibble to display
//              OUT   [6:0] registered segment drive {g,f,e,d,c,b,a}, bit0 = a
//              I_RBI       ripple-blank in (SEVENSEG_RBL_EN only)
//              O_RBO       ripple-blank out, combinational (SEVENSEG_RBL_EN only)
//
// Optional feature macro: SEVENSEG_RBL_EN enables leading-zero suppression.
// With it, a zero nibble whose I_RBI is high shows blank, and O_RBO tells the
// next lower digit that everything above it is still blank zeros.
//
// There is no FSM; the only state is the OUT register.

module seven_seg (
    input  logic       I_CLK,
    input  logic       I_RST_N,
    seven_seg_if.slave bus
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [6:0] next_seg;
    logic [6:0] seg_q;

    // Pure lookup. Any non-0..F value (X/Z in simulation) falls to the
    // default and shows blank rather than a plausible glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;  // A
            4'hB:    g = 7'h03;  // b (lowercase)
            4'hC:    g = 7'h46;  // C
            4'hD:    g = 7'h21;  // d (lowercase)
            4'hE:    g = 7'h06;  // E
            4'hF:    g = 7'h0E;  // F
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    always_comb begin
        next_seg = hex_glyph(bus.IN);
`ifdef SEVENSEG_RBL_EN
        // Leading zero: every digit above this one is blank, so blank too.
        if (bus.I_RBI && (bus.IN == 4'h0)) begin
            next_seg = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            seg_q <= SEG_BLANK;
        end else begin
            seg_q <= next_seg;
        end
    end

    assign bus.OUT = seg_q;

`ifdef SEVENSEG_RBL_EN
    // Deliberately not reset-gated and not registered, so a whole chain of
    // digits settles within the same cycle as its IN values.
    assign bus.O_RBO = bus.I_RBI & (bus.IN == 4'h0);
`endif

endmodule

// File: tb/tb_seven_seg.sv
// tb_seven_seg: four chained seven_seg digits showing a 16-bit value,
// checked against a reference model of the display rules.

module tb_seven_seg;

`ifdef SEVENSEG_RBL_EN
    localparam bit RBL_EN = 1'b1;
`else
    localparam bit RBL_EN = 1'b0;
`endif

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        I_CLK;
    logic        I_RST_N;
    logic [15:0] value;

    int n_cmp;
    int n_bad;
    logic [27:0] exp_q[$];

    seven_seg_if if0 ();
    seven_seg_if if1 ();
    seven_seg_if if2 ();
    seven_seg_if if3 ();

    assign if0.IN = value[3:0];
    assign if1.IN = value[7:4];
    assign if2.IN = value[11:8];
    assign if3.IN = value[15:12];

`ifdef SEVENSEG_RBL_EN
    assign if3.I_RBI = 1'b1;
    assign if2.I_RBI = if3.O_RBO;
    assign if1.I_RBI = if2.O_RBO;
    assign if0.I_RBI = 1'b0;
`endif

    seven_seg dut0 (.I_CLK(I_CLK), .I_RST_N(I_RST_N), .bus(if0));
    seven_seg dut1 (.I_CLK(I_CLK), .I_RST_N(I_RST_N), .bus(if1));
    seven_seg dut2 (.I_CLK(I_CLK), .I_RST_N(I_RST_N), .bus(if2));
    seven_seg dut3 (.I_CLK(I_CLK), .I_RST_N(I_RST_N), .bus(if3));

    // ---------------- clock / reset ----------------
    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    // ---------------- reference model ----------------
    // Digit i is a leading zero when the value shifted down to it is zero;
    // the least significant digit is never blanked.
    function automatic logic [27:0] model_out(input logic [15:0] v);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] nib;
            nib = 4'((v >> (4 * i)) & 16'hF);
            if (RBL_EN && i > 0 && (v >> (4 * i)) == 16'h0)
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = GLYPH[nib];
        end
        return r;
    endfunction

    function automatic logic [3:0] model_rbo(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 1; i < 4; i++) begin
            r[i] = ((v >> (4 * i)) == 16'h0);
        end
        return r;
    endfunction

    function automatic logic [27:0] all_out();
        return {if3.OUT, if2.OUT, if1.OUT, if0.OUT};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (value=0x%04h t=%0t)", tag, got, exp, value, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Apply a value after a falling edge, check the combinational ripple-blank
    // outputs, then check the registered glyphs just after the next rising edge.
    task automatic cycle(input string tag, input logic [15:0] v);
        @(negedge I_CLK);
        value = v;
        exp_q.push_back(model_out(v));
`ifdef SEVENSEG_RBL_EN
        #1;
        check({tag, "_rbo"}, 32'({if3.O_RBO, if2.O_RBO, if1.O_RBO, if0.O_RBO}), 32'(model_rbo(v)));
`endif
        @(posedge I_CLK);
        #1;
        check(tag, 32'(all_out()), 32'(exp_q.pop_front()));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        I_RST_N = 1'b0;
        value   = 16'h8888;

        // Reset held with clock running: display blank throughout.
        repeat (3) begin
            @(posedge I_CLK);
            #1;
            check("reset_hold", 32'(all_out()), 32'h0FFF_FFFF);
        end
        @(negedge I_CLK);
        I_RST_N = 1'b1;
        #1;
        check("reset_release_pre", 32'(all_out()), 32'h0FFF_FFFF);
        @(posedge I_CLK);
        #1;
        check("reset_release", 32'(all_out()), 32'(model_out(16'h8888)));

        // Full sweep, one nibble value per cycle on every digit.
        for (int n = 0; n < 16; n++) begin
            cycle("sweep", {4{4'(n)}});
        end
        // Single-digit sweep on the least significant digit.
        for (int n = 0; n < 16; n++) begin
            cycle("sweep_lsd", 16'(n));
        end

        // Async reset between edges blanks at once.
        cycle("pre_async", 16'h5555);
        #2;
        I_RST_N = 1'b0;
        #1;
        check("async_reset", 32'(all_out()), 32'h0FFF_FFFF);
        @(negedge I_CLK);
        check("async_reset_hold", 32'(all_out()), 32'h0FFF_FFFF);
        I_RST_N = 1'b1;

        // Hold a value: output stays steady.
        repeat (10) cycle("hold", 16'hAAAA);

        // Chain example and leading-zero boundaries.
        cycle("chain_0040", 16'h0040);
        cycle("chain_0000", 16'h0000);
        cycle("chain_0001", 16'h0001);
        cycle("chain_1000", 16'h1000);
        cycle("chain_0100", 16'h0100);
        cycle("chain_0010", 16'h0010);
        cycle("chain_ffff", 16'hFFFF);

        // Random values, with a bias toward leading zeros.
        for (int k = 0; k < 300; k++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v >> ($urandom_range(1, 3) * 4);
                default: ;
            endcase
            cycle("random", v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
